// File: rtl/draw_bg_pattern_if.sv
// VGA timing bundle: counters, syncs, blanking and pixel colour travelling together.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_bg_pattern.sv
// Background generator: border, solid/checker/gradient/tint pattern and blinking border,
// with frame-synchronous settings and a fixed-latency timing pipeline.
module draw_bg_pattern #(
    parameter int unsigned H_ACTIVE     = 800,
    parameter int unsigned V_ACTIVE     = 600,
    parameter int unsigned BORDER_W     = 1,
    parameter int unsigned TILE_LOG2    = 5,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned PIPE_DEPTH   = 1
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           in,
    vga_if.out          out,
    input  logic [1:0]  mode_i,
    input  logic [11:0] fill_rgb_i,
    input  logic [11:0] alt_rgb_i,
    input  logic        blink_en_i,
    output logic        border_on_o
);

    localparam int unsigned CNT_W = $clog2(BLINK_FRAMES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [10:0] TOP_END   = 11'(BORDER_W);
    localparam logic [10:0] BOT_START = 11'(V_ACTIVE - BORDER_W);
    localparam logic [10:0] LEFT_END  = 11'(BORDER_W);
    localparam logic [10:0] RIGHT_BEG = 11'(H_ACTIVE - BORDER_W);

    typedef struct packed {
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } pix_t;

    logic             vblnk_q;
    logic             frame_start;
    logic [1:0]       shd_mode;
    logic [11:0]      shd_fill;
    logic [11:0]      shd_alt;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_en_q;
    logic [11:0]      pattern;
    logic [11:0]      pix_rgb;
    pix_t             stage_in;
    pix_t             pipe [PIPE_DEPTH];

    assign frame_start = in.vblnk & ~vblnk_q;

    // Settings only change at a frame boundary so a frame is never drawn half-and-half.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q  <= 1'b0;
            shd_mode <= 2'd0;
            shd_fill <= 12'h888;
            shd_alt  <= 12'h887;
        end else begin
            vblnk_q <= in.vblnk;
            if (frame_start) begin
                shd_mode <= mode_i;
                shd_fill <= fill_rgb_i;
                shd_alt  <= alt_rgb_i;
            end
        end
    end

    // A frame start coinciding with the enable rising does not count: counting restarts from 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            border_on_o <= 1'b1;
            blink_en_q  <= 1'b0;
        end else begin
            blink_en_q <= blink_en_i;
            if (!blink_en_i) begin
                blink_cnt   <= '0;
                border_on_o <= 1'b1;
            end else if (frame_start && blink_en_q) begin
                if (blink_cnt == CNT_LAST) begin
                    blink_cnt   <= '0;
                    border_on_o <= ~border_on_o;
                end else begin
                    blink_cnt <= blink_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        pattern = shd_fill;
        case (shd_mode)
            2'd0:    pattern = shd_fill;
            2'd1:    pattern = (in.hcount[TILE_LOG2] ^ in.vcount[TILE_LOG2]) ? shd_alt : shd_fill;
            2'd2:    pattern = {in.hcount[9:6], shd_fill[7:0]};
            default: pattern = (in.rgb == 12'h000) ? shd_fill : shd_alt;
        endcase
    end

    // Blanking beats border, border beats pattern; hidden border shows the pattern.
    always_comb begin
        pix_rgb = pattern;
        if (in.vblnk || in.hblnk) begin
            pix_rgb = 12'h000;
        end else if (border_on_o) begin
            if (in.vcount < TOP_END)          pix_rgb = 12'hff0;
            else if (in.vcount >= BOT_START)  pix_rgb = 12'hf00;
            else if (in.hcount < LEFT_END)    pix_rgb = 12'h0f0;
            else if (in.hcount >= RIGHT_BEG)  pix_rgb = 12'h00f;
        end
    end

    always_comb begin
        stage_in.vcount = in.vcount;
        stage_in.vsync  = in.vsync;
        stage_in.vblnk  = in.vblnk;
        stage_in.hcount = in.hcount;
        stage_in.hsync  = in.hsync;
        stage_in.hblnk  = in.hblnk;
        stage_in.rgb    = pix_rgb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(PIPE_DEPTH); i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= stage_in;
            for (int i = 1; i < int'(PIPE_DEPTH); i++) pipe[i] <= pipe[i-1];
        end
    end

    assign out.vcount = pipe[PIPE_DEPTH-1].vcount;
    assign out.vsync  = pipe[PIPE_DEPTH-1].vsync;
    assign out.vblnk  = pipe[PIPE_DEPTH-1].vblnk;
    assign out.hcount = pipe[PIPE_DEPTH-1].hcount;
    assign out.hsync  = pipe[PIPE_DEPTH-1].hsync;
    assign out.hblnk  = pipe[PIPE_DEPTH-1].hblnk;
    assign out.rgb    = pipe[PIPE_DEPTH-1].rgb;

endmodule

// File: tb/tb_draw_bg_pattern.sv
// Directed bench for draw_bg_pattern: BORDER_W=2, BLINK_FRAMES=2, PIPE_DEPTH=2.
module tb_draw_bg_pattern;
    localparam int PD = 2;

    logic        clk;
    logic        rst;
    logic [1:0]  mode_i;
    logic [11:0] fill_rgb_i;
    logic [11:0] alt_rgb_i;
    logic        blink_en_i;
    logic        border_on_o;
    int          tests;
    int          fails;

    vga_if vin ();
    vga_if vout ();

    draw_bg_pattern #(
        .H_ACTIVE(800), .V_ACTIVE(600), .BORDER_W(2), .TILE_LOG2(5),
        .BLINK_FRAMES(2), .PIPE_DEPTH(PD)
    ) dut (
        .clk(clk), .rst(rst), .in(vin), .out(vout),
        .mode_i(mode_i), .fill_rgb_i(fill_rgb_i), .alt_rgb_i(alt_rgb_i),
        .blink_en_i(blink_en_i), .border_on_o(border_on_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_pix(input int h, input int v, input logic hb, input logic [11:0] rgb);
        @(negedge clk);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hblnk  = hb;
        vin.rgb    = rgb;
    endtask

    // Drive a pixel and wait until it reaches the output.
    task automatic pix(input int h, input int v, input logic hb, input logic [11:0] rgb);
        set_pix(h, v, hb, rgb);
        repeat (PD) @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        vin.vblnk = 1'b1;
        @(negedge clk);
        vin.vblnk = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_pix(5, 9, 1'b0, 12'h321);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (vout.hcount !== 11'd0 || vout.vcount !== 11'd0 || vout.rgb !== 12'h000) begin
            fails++;
            $display("FAIL reset_out h=%0d v=%0d rgb=%h expected 0/0/000", vout.hcount, vout.vcount, vout.rgb);
        end
        tests++;
        if (border_on_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_border_on got=%b expected=1", border_on_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_solid();
        // Mode/fill inputs change but no frame start: reset shadow (mode 0, 888) must be used.
        mode_i = 2'd0; fill_rgb_i = 12'h111; alt_rgb_i = 12'heee;
        pix(7, 100, 1'b0, 12'h000);
        set_pix(100, 100, 1'b0, 12'h000);
        repeat (PD - 1) @(posedge clk);
        #1;
        tests++;
        if (vout.hcount !== 11'd7) begin
            fails++;
            $display("FAIL latency_early hcount=%0d expected=7", vout.hcount);
        end
        @(posedge clk);
        #1;
        tests++;
        if (vout.rgb !== 12'h888 || vout.hcount !== 11'd100 || vout.vcount !== 11'd100) begin
            fails++;
            $display("FAIL solid_reset_fill rgb=%h h=%0d v=%0d expected 888/100/100", vout.rgb, vout.hcount, vout.vcount);
        end
    endtask

    task automatic test_checker();
        frame_pulse();
        mode_i = 2'd1;
        pix(32, 64, 1'b0, 12'h000);
        tests++;
        if (vout.rgb !== 12'h111) begin
            fails++;
            $display("FAIL checker_midframe rgb=%h expected=111", vout.rgb);
        end
        frame_pulse();
        pix(32, 64, 1'b0, 12'h000);
        tests++;
        if (vout.rgb !== 12'heee) begin
            fails++;
            $display("FAIL checker_odd rgb=%h expected=eee", vout.rgb);
        end
        pix(32, 32, 1'b0, 12'h000);
        tests++;
        if (vout.rgb !== 12'h111) begin
            fails++;
            $display("FAIL checker_even rgb=%h expected=111", vout.rgb);
        end
    endtask

    task automatic test_border();
        int          hs [6]  = '{0, 799, 1, 798, 2, 100};
        int          vs [6]  = '{0, 599, 300, 300, 300, 100};
        logic        hbs [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [11:0] exp [6] = '{12'hff0, 12'hf00, 12'h0f0, 12'h00f, 12'heee, 12'h000};
        for (int i = 0; i < 6; i++) begin
            pix(hs[i], vs[i], hbs[i], 12'h000);
            tests++;
            if (vout.rgb !== exp[i]) begin
                fails++;
                $display("FAIL border_%0d pixel(%0d,%0d) rgb=%h expected=%h", i, hs[i], vs[i], vout.rgb, exp[i]);
            end
        end
    endtask

    task automatic test_tint_gradient();
        mode_i = 2'd3; fill_rgb_i = 12'h5a5; alt_rgb_i = 12'h3c3;
        frame_pulse();
        pix(100, 300, 1'b0, 12'h000);
        tests++;
        if (vout.rgb !== 12'h5a5) begin
            fails++;
            $display("FAIL tint_black rgb=%h expected=5a5", vout.rgb);
        end
        pix(100, 300, 1'b0, 12'h123);
        tests++;
        if (vout.rgb !== 12'h3c3) begin
            fails++;
            $display("FAIL tint_colour rgb=%h expected=3c3", vout.rgb);
        end
        mode_i = 2'd2;
        frame_pulse();
        pix(640, 300, 1'b0, 12'h000);
        tests++;
        if (vout.rgb !== 12'haa5) begin
            fails++;
            $display("FAIL gradient_640 rgb=%h expected=aa5", vout.rgb);
        end
    endtask

    task automatic test_blink();
        logic exp_on;
        mode_i = 2'd0; fill_rgb_i = 12'h5a5;
        frame_pulse();
        @(negedge clk);
        blink_en_i = 1'b1;
        repeat (2) @(negedge clk);
        exp_on = 1'b1;
        for (int ev = 1; ev <= 6; ev++) begin
            frame_pulse();
            if (ev % 2 == 0) exp_on = ~exp_on;
            tests++;
            if (border_on_o !== exp_on) begin
                fails++;
                $display("FAIL blink_event_%0d border_on=%b expected=%b", ev, border_on_o, exp_on);
            end
            if (ev == 2) begin
                pix(0, 0, 1'b0, 12'h000);
                tests++;
                if (vout.rgb !== 12'h5a5) begin
                    fails++;
                    $display("FAIL blink_hidden_border rgb=%h expected=5a5", vout.rgb);
                end
            end
        end
        @(negedge clk);
        blink_en_i = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (border_on_o !== 1'b1) begin
            fails++;
            $display("FAIL blink_disable border_on=%b expected=1", border_on_o);
        end
    endtask

    task automatic test_reset_midline();
        mode_i = 2'd2; fill_rgb_i = 12'h5a5;
        pix(100, 100, 1'b0, 12'h000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (vout.rgb !== 12'h000 || vout.hcount !== 11'd0 || vout.vcount !== 11'd0) begin
            fails++;
            $display("FAIL rst_pulse_out rgb=%h h=%0d v=%0d expected 000/0/0", vout.rgb, vout.hcount, vout.vcount);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (PD - 1) @(posedge clk);
        #1;
        tests++;
        if (vout.hcount !== 11'd0 || vout.rgb !== 12'h000) begin
            fails++;
            $display("FAIL rst_flush h=%0d rgb=%h expected 0/000", vout.hcount, vout.rgb);
        end
        @(posedge clk);
        #1;
        tests++;
        if (vout.rgb !== 12'h888 || vout.hcount !== 11'd100) begin
            fails++;
            $display("FAIL rst_recover rgb=%h h=%0d expected 888/100", vout.rgb, vout.hcount);
        end
        frame_pulse();
        pix(100, 100, 1'b0, 12'h000);
        tests++;
        if (vout.rgb !== 12'h1a5) begin
            fails++;
            $display("FAIL rst_then_frame rgb=%h expected=1a5", vout.rgb);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        mode_i = 2'd0; fill_rgb_i = 12'h000; alt_rgb_i = 12'h000; blink_en_i = 1'b0;
        vin.vcount = '0; vin.vsync = 1'b0; vin.vblnk = 1'b0;
        vin.hcount = '0; vin.hsync = 1'b0; vin.hblnk = 1'b0; vin.rgb = '0;
        test_reset();
        test_solid();
        test_checker();
        test_border();
        test_tint_gradient();
        test_blink();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
